// File: rtl/z3_master_cycle_if.sv
// Local DMA request/response and Zorro III bus signals for the master cycle engine.
// master = the cycle engine; slave = the local requester plus the Zorro bus side.
interface z3_master_cycle_if;
    logic        req;
    logic [31:0] addr;
    logic        read;
    logic [1:0]  siz;
    logic [31:0] wdata;
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic        BMASTER;
    logic        DTACK_n;
    logic        BERR_n;
    logic [31:0] D_in;
    logic [31:0] Z_A;
    logic        ABOE;
    logic        FCS_n;
    logic        DOE;
    logic [3:0]  DS_n;
    logic        Z_READ;
    logic [31:0] D_out;
    logic        DBOE;

    modport master (
        input  req, addr, read, siz, wdata, BMASTER, DTACK_n, BERR_n, D_in,
        output ack, err, rdata, Z_A, ABOE, FCS_n, DOE, DS_n, Z_READ, D_out, DBOE
    );

    modport slave (
        output req, addr, read, siz, wdata, BMASTER, DTACK_n, BERR_n, D_in,
        input  ack, err, rdata, Z_A, ABOE, FCS_n, DOE, DS_n, Z_READ, D_out, DBOE
    );
endinterface

// File: rtl/z3_master_cycle.sv
// Zorro III bus-master cycle engine: turns one local DMA request into a full
// address/strobe/wait/terminate sequence with timeout and bus-error reporting.
module z3_master_cycle #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST,
    z3_master_cycle_if.master bus
);
    localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_STROBE, S_WAIT, S_TERM, S_END
    } state_t;

    state_t        r_state;
    logic [1:0]    r_dtk_sync;
    logic [1:0]    r_be_sync;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_addr;
    logic          r_read;
    logic [1:0]    r_siz;
    logic [31:0]   r_wdata;
    logic          r_ack;
    logic          r_err;
    logic [31:0]   r_rdata;
    logic          r_aboe;
    logic          r_fcs_n;
    logic          r_doe;
    logic [3:0]    r_ds_n;
    logic          r_zread;
    logic          r_dboe;

    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_cnt_inc;
    logic          w_capture;
    logic          w_dtk;
    logic          w_be;
    logic          w_timeout;
    logic          w_err_term;
    logic          w_read_sel;
    logic [3:0]    w_ds_mask;
    logic          w_ack_nxt;
    logic          w_err_nxt;
    logic [31:0]   w_rdata_nxt;
    logic          w_aboe_nxt;
    logic          w_fcs_n_nxt;
    logic          w_doe_nxt;
    logic [3:0]    w_ds_n_nxt;
    logic          w_zread_nxt;
    logic          w_dboe_nxt;

    // Active-low byte strobes for lanes off..off+n-1, clipped at lane 3; lane 0 is DS_n[3].
    function automatic logic [3:0] lane_mask(input logic [1:0] off, input logic [1:0] sz);
        logic [2:0] n;
        logic [3:0] m;
        n = (sz == 2'b00) ? 3'd4 : {1'b0, sz};
        m = 4'hF;
        for (int k = 0; k < 4; k++) begin
            if ((3'(k) >= {1'b0, off}) && (3'(k) < ({1'b0, off} + n)))
                m[2'(3 - k)] = 1'b0;
        end
        return m;
    endfunction

    assign w_dtk = ~r_dtk_sync[1];
    assign w_be  = ~r_be_sync[1];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_cnt_inc   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);
        w_timeout   = (w_cnt_inc >= CNT_LIM);
        w_err_term  = w_be | (w_timeout & ~w_dtk);

        case (r_state)
            S_IDLE: begin
                if (bus.req && bus.BMASTER && !w_be) begin
                    w_state_nxt = S_ADDR;
                    w_capture   = 1'b1;
                end
            end
            S_ADDR: begin
                w_state_nxt = S_STROBE;
                w_cnt_nxt   = '0;
            end
            S_STROBE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                w_cnt_nxt = w_cnt_inc;
                if (w_be || w_dtk || w_timeout)
                    w_state_nxt = S_TERM;
            end
            S_TERM: w_state_nxt = S_END;
            S_END: begin
                if (!w_dtk && !w_be)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_read_sel = w_capture ? bus.read : r_read;
        w_ds_mask  = r_read ? 4'h0 : lane_mask(r_addr[1:0], r_siz);

        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_rdata_nxt = '0;
        w_aboe_nxt  = 1'b0;
        w_fcs_n_nxt = 1'b1;
        w_doe_nxt   = 1'b0;
        w_ds_n_nxt  = 4'hF;
        w_zread_nxt = 1'b1;
        w_dboe_nxt  = 1'b0;

        // Bus outputs are registered against the state being entered.
        if (w_state_nxt inside {S_ADDR, S_STROBE, S_WAIT, S_TERM}) begin
            w_aboe_nxt  = 1'b1;
            w_zread_nxt = w_read_sel;
        end
        if (w_state_nxt inside {S_STROBE, S_WAIT, S_TERM}) begin
            w_fcs_n_nxt = 1'b0;
            w_doe_nxt   = 1'b1;
            w_dboe_nxt  = ~r_read;
        end
        if (w_state_nxt inside {S_WAIT, S_TERM})
            w_ds_n_nxt = w_ds_mask;
        if (w_state_nxt == S_TERM) begin
            w_ack_nxt   = 1'b1;
            w_err_nxt   = w_err_term;
            w_rdata_nxt = (r_read && !w_err_term) ? bus.D_in : 32'h0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_dtk_sync <= 2'b11;
            r_be_sync  <= 2'b11;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_read     <= 1'b1;
            r_siz      <= 2'b00;
            r_wdata    <= '0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_aboe     <= 1'b0;
            r_fcs_n    <= 1'b1;
            r_doe      <= 1'b0;
            r_ds_n     <= 4'hF;
            r_zread    <= 1'b1;
            r_dboe     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dtk_sync <= {r_dtk_sync[0], bus.DTACK_n};
            r_be_sync  <= {r_be_sync[0], bus.BERR_n};
            r_cnt      <= w_cnt_nxt;
            if (w_capture) begin
                r_addr  <= bus.addr;
                r_read  <= bus.read;
                r_siz   <= bus.siz;
                r_wdata <= bus.wdata;
            end
            r_ack      <= w_ack_nxt;
            r_err      <= w_err_nxt;
            r_rdata    <= w_rdata_nxt;
            r_aboe     <= w_aboe_nxt;
            r_fcs_n    <= w_fcs_n_nxt;
            r_doe      <= w_doe_nxt;
            r_ds_n     <= w_ds_n_nxt;
            r_zread    <= w_zread_nxt;
            r_dboe     <= w_dboe_nxt;
        end
    end

    assign bus.ack    = r_ack;
    assign bus.err    = r_err;
    assign bus.rdata  = r_rdata;
    assign bus.Z_A    = r_addr;
    assign bus.ABOE   = r_aboe;
    assign bus.FCS_n  = r_fcs_n;
    assign bus.DOE    = r_doe;
    assign bus.DS_n   = r_ds_n;
    assign bus.Z_READ = r_zread;
    assign bus.D_out  = r_wdata;
    assign bus.DBOE   = r_dboe;
endmodule

// File: tb/tb_z3_master_cycle.sv
// Directed bench for z3_master_cycle (TIMEOUT=8): reads, writes, lane masks,
// timeout, bus error, arbitration and mid-cycle reset.
module tb_z3_master_cycle;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    z3_master_cycle_if bif ();
    z3_master_cycle #(.TIMEOUT(8)) dut (.CLK(clk), .RST(rst), .bus(bif.master));

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one request; DTACK_n drops dly cycles after FCS_n is first seen low (dly<0: never).
    task automatic do_cycle(input logic [31:0] a, input logic rd, input logic [1:0] sz,
                            input logic [31:0] wd, input int dly,
                            output logic got, output logic e, output logic [31:0] rdat,
                            output logic [3:0] ds, output int nwait, output logic dboe_all,
                            output logic [31:0] dout, output logic fcs_after);
        int fcs_cyc;
        bif.addr = a; bif.read = rd; bif.siz = sz; bif.wdata = wd; bif.req = 1'b1;
        got = 1'b0; e = 1'b0; rdat = '0; ds = 4'hF; nwait = 0; dboe_all = 1'b1;
        dout = '0; fcs_after = 1'b0; fcs_cyc = -1;
        for (int n = 0; n < 64 && !got; n++) begin
            @(posedge clk); #1;
            if (fcs_cyc < 0 && bif.FCS_n == 1'b0) fcs_cyc = n;
            if (fcs_cyc >= 0) begin
                if (!bif.DBOE) dboe_all = 1'b0;
                if (bif.DS_n != 4'hF && ds == 4'hF) ds = bif.DS_n;
                if (bif.ack) begin
                    got = 1'b1; e = bif.err; rdat = bif.rdata; dout = bif.D_out;
                end else if (bif.DS_n != 4'hF) begin
                    nwait++;
                end
                if (dly >= 0 && (n - fcs_cyc) == dly) bif.DTACK_n = 1'b0;
            end
        end
        bif.req = 1'b0;
        @(posedge clk); #1;
        fcs_after = bif.FCS_n;
        bif.DTACK_n = 1'b1; bif.BERR_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Completes an in-flight cycle by answering FCS_n with DTACK_n.
    task automatic finish_cycle(output logic got, output logic e);
        got = 1'b0; e = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(posedge clk); #1;
            if (bif.ack) begin
                got = 1'b1; e = bif.err;
            end else if (!bif.FCS_n) begin
                bif.DTACK_n = 1'b0;
            end
        end
        bif.DTACK_n = 1'b1; bif.BERR_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        logic        got, e, fa, dba, seen;
        logic [31:0] rd, dout;
        logic [3:0]  ds;
        int          nw, cnt;

        rst = 1'b1;
        bif.req = 1'b0; bif.addr = '0; bif.read = 1'b0; bif.siz = 2'b00; bif.wdata = '0;
        bif.BMASTER = 1'b1; bif.DTACK_n = 1'b1; bif.BERR_n = 1'b1; bif.D_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fcs", 32'(bif.FCS_n), 32'h1);
        chk("rst_ds", 32'(bif.DS_n), 32'hF);
        chk("rst_doe", 32'(bif.DOE), 32'h0);
        chk("rst_dboe", 32'(bif.DBOE), 32'h0);
        chk("rst_aboe", 32'(bif.ABOE), 32'h0);
        chk("rst_zread", 32'(bif.Z_READ), 32'h1);
        chk("rst_ack", 32'(bif.ack), 32'h0);
        chk("rst_err", 32'(bif.err), 32'h0);
        chk("rst_rdata", bif.rdata, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Longword read
        bif.D_in = 32'hDEADBEEF;
        do_cycle(32'h40100000, 1'b1, 2'b00, 32'h0, 3, got, e, rd, ds, nw, dba, dout, fa);
        chk("rd_ack", 32'(got), 32'h1);
        chk("rd_err", 32'(e), 32'h0);
        chk("rd_data", rd, 32'hDEADBEEF);
        chk("rd_ds", 32'(ds), 32'h0);
        chk("rd_fcs_after", 32'(fa), 32'h1);

        // Byte write at offset 3
        do_cycle(32'h40100003, 1'b0, 2'b01, 32'h000000A5, 0, got, e, rd, ds, nw, dba, dout, fa);
        chk("bw_ack", 32'(got), 32'h1);
        chk("bw_err", 32'(e), 32'h0);
        chk("bw_ds", 32'(ds), 32'hE);
        chk("bw_dboe", 32'(dba), 32'h1);
        chk("bw_dout", dout, 32'h000000A5);

        // Lane masks, clipping and read-all-lanes
        do_cycle(32'h40100003, 1'b0, 2'b10, 32'h1234, 0, got, e, rd, ds, nw, dba, dout, fa);
        chk("clip_o3_s2", 32'(ds), 32'hE);
        do_cycle(32'h40100001, 1'b0, 2'b11, 32'h123456, 0, got, e, rd, ds, nw, dba, dout, fa);
        chk("clip_o1_s3", 32'(ds), 32'h8);
        do_cycle(32'h40100002, 1'b0, 2'b10, 32'h5678, 0, got, e, rd, ds, nw, dba, dout, fa);
        chk("ds_o2_s2", 32'(ds), 32'hC);
        do_cycle(32'h40100000, 1'b0, 2'b00, 32'hCAFEF00D, 0, got, e, rd, ds, nw, dba, dout, fa);
        chk("ds_o0_s0", 32'(ds), 32'h0);
        chk("lw_dout", dout, 32'hCAFEF00D);
        bif.D_in = 32'h0BADF00D;
        do_cycle(32'h40100001, 1'b1, 2'b01, 32'h0, 0, got, e, rd, ds, nw, dba, dout, fa);
        chk("rd_byte_ds", 32'(ds), 32'h0);
        chk("rd_byte_data", rd, 32'h0BADF00D);

        // Timeout: no DTACK
        do_cycle(32'h40200000, 1'b1, 2'b00, 32'h0, -1, got, e, rd, ds, nw, dba, dout, fa);
        chk("to_ack", 32'(got), 32'h1);
        chk("to_err", 32'(e), 32'h1);
        chk("to_rdata", rd, 32'h0);
        chk("to_waits", 32'(nw), 32'd8);

        // BERR and DTACK together; END holds while either is low
        bif.addr = 32'h40300000; bif.read = 1'b1; bif.siz = 2'b00; bif.req = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(posedge clk); #1;
            seen = !bif.FCS_n;
        end
        chk("be_fcs_seen", 32'(seen), 32'h1);
        bif.DTACK_n = 1'b0; bif.BERR_n = 1'b0;
        got = 1'b0; e = 1'b0; rd = 32'hFFFFFFFF;
        for (int n = 0; n < 12 && !got; n++) begin
            @(posedge clk); #1;
            if (bif.ack) begin got = 1'b1; e = bif.err; rd = bif.rdata; end
        end
        chk("be_ack", 32'(got), 32'h1);
        chk("be_err", 32'(e), 32'h1);
        chk("be_rdata", rd, 32'h0);
        bif.BERR_n = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bif.ABOE) cnt++;
        end
        chk("be_end_hold", 32'(cnt), 32'h0);
        bif.DTACK_n = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 8 && !seen; n++) begin
            @(posedge clk); #1;
            seen = bif.ABOE;
        end
        chk("be_end_exit", 32'(seen), 32'h1);
        bif.req = 1'b0;
        finish_cycle(got, e);
        chk("be_next_ack", 32'(got), 32'h1);

        // No grant: no bus activity
        bif.BMASTER = 1'b0; bif.req = 1'b1; cnt = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (!bif.FCS_n || bif.ABOE) cnt++;
        end
        chk("nogrant_idle", 32'(cnt), 32'h0);
        bif.req = 1'b0; bif.BMASTER = 1'b1;
        @(posedge clk); #1;

        // Reset in WAIT, then req still high starts a new cycle that survives grant loss
        bif.addr = 32'h40400000; bif.read = 1'b0; bif.siz = 2'b00; bif.wdata = 32'h11223344;
        bif.req = 1'b1; seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(posedge clk); #1;
            seen = (bif.DS_n != 4'hF);
        end
        chk("mid_wait_seen", 32'(seen), 32'h1);
        chk("mid_wait_dboe", 32'(bif.DBOE), 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_fcs", 32'(bif.FCS_n), 32'h1);
        chk("mid_rst_ds", 32'(bif.DS_n), 32'hF);
        chk("mid_rst_doe", 32'(bif.DOE), 32'h0);
        chk("mid_rst_dboe", 32'(bif.DBOE), 32'h0);
        chk("mid_rst_aboe", 32'(bif.ABOE), 32'h0);
        chk("mid_rst_zread", 32'(bif.Z_READ), 32'h1);
        chk("mid_rst_ack", 32'(bif.ack), 32'h0);
        rst = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 6 && !seen; n++) begin
            @(posedge clk); #1;
            seen = bif.ABOE;
        end
        chk("post_rst_new_req", 32'(seen), 32'h1);
        bif.BMASTER = 1'b0; bif.req = 1'b0;
        finish_cycle(got, e);
        chk("nogrant_inflight_ack", 32'(got), 32'h1);
        chk("nogrant_inflight_err", 32'(e), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
